// File: rtl/hazard_unit_mc.sv
`default_nettype none
// ============================================================================
// hazard_unit_mc : pipeline stall/flush/forwarding control with multi-cycle
//                  EX op sequencer and stall performance counter
// Revision 1.0
// ============================================================================
module hazard_unit_mc #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LAT     = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  CPU_CLK,
  input  logic                  CPU_RST_N,
  input  logic                  ICacheMiss,
  input  logic                  DCacheMiss,
  input  logic                  BranchE,
  input  logic                  JalrE,
  input  logic                  JalD,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic [1:0]            RegReadE,
  input  logic [2:0]            MemToRegE,
  input  logic [2:0]            RegWriteM,
  input  logic [2:0]            RegWriteW,
  input  logic                  McStartE,
  input  logic                  PerfClr,
  output logic                  StallF,
  output logic                  FlushF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  StallE,
  output logic                  FlushE,
  output logic                  StallM,
  output logic                  FlushM,
  output logic                  StallW,
  output logic                  FlushW,
  output logic [1:0]            Forward1E,
  output logic [1:0]            Forward2E,
  output logic                  McBusy,
  output logic [CNT_W-1:0]      PerfStallCnt
);

  localparam logic [3:0] C_MC_LOAD = 4'(MC_LAT - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_mc_cnt, w_mc_cnt_nxt;
  logic [CNT_W-1:0] r_perf_cnt;

  logic w_miss, w_mc_stall, w_branch, w_load_use;

  assign w_miss     = ICacheMiss | DCacheMiss;
  assign w_mc_stall = ((r_state == S_IDLE) && McStartE) || (r_state == S_BUSY);
  assign w_branch   = BranchE | JalrE;
  assign w_load_use = (MemToRegE != 3'd0) && (RdE != '0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      r_state  <= S_IDLE;
      r_mc_cnt <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_mc_cnt <= w_mc_cnt_nxt;
    end
  end

  // A miss freezes the sequencer in whatever state it is in.
  always_comb begin
    w_state_nxt  = r_state;
    w_mc_cnt_nxt = r_mc_cnt;
    if (!w_miss) begin
      case (r_state)
        S_IDLE: begin
          if (McStartE) begin
            w_state_nxt  = S_BUSY;
            w_mc_cnt_nxt = C_MC_LOAD;
          end
        end
        S_BUSY: begin
          if (r_mc_cnt == 4'd0) w_state_nxt = S_DONE;
          else                  w_mc_cnt_nxt = r_mc_cnt - 4'd1;
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    StallF = 1'b0; FlushF = 1'b0;
    StallD = 1'b0; FlushD = 1'b0;
    StallE = 1'b0; FlushE = 1'b0;
    StallM = 1'b0; FlushM = 1'b0;
    StallW = 1'b0; FlushW = 1'b0;
    if (!CPU_RST_N) begin
      FlushF = 1'b1; FlushD = 1'b1; FlushE = 1'b1; FlushM = 1'b1; FlushW = 1'b1;
    end else if (w_miss) begin
      StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1; StallW = 1'b1;
    end else if (w_mc_stall) begin
      // Hold F/D/E around the multi-cycle op and bubble MEM behind it.
      StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; FlushM = 1'b1;
    end else if (w_branch) begin
      FlushD = 1'b1; FlushE = 1'b1;
    end else if (w_load_use) begin
      StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
    end else if (JalD) begin
      FlushD = 1'b1;
    end
  end

  always_comb begin
    Forward1E = 2'b00;
    Forward2E = 2'b00;
    if (CPU_RST_N) begin
      if ((RegWriteM != 3'd0) && RegReadE[1] && (RdM == Rs1E) && (RdM != '0))
        Forward1E = 2'b10;
      else if ((RegWriteW != 3'd0) && RegReadE[1] && (RdW == Rs1E) && (RdW != '0))
        Forward1E = 2'b01;
      if ((RegWriteM != 3'd0) && RegReadE[0] && (RdM == Rs2E) && (RdM != '0))
        Forward2E = 2'b10;
      else if ((RegWriteW != 3'd0) && RegReadE[0] && (RdW == Rs2E) && (RdW != '0))
        Forward2E = 2'b01;
    end
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      r_perf_cnt <= '0;
    end else if (PerfClr) begin
      r_perf_cnt <= '0;
    end else if (StallF && !w_miss && !(&r_perf_cnt)) begin
      r_perf_cnt <= r_perf_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign McBusy       = (r_state != S_IDLE);
  assign PerfStallCnt = r_perf_cnt;

endmodule
`default_nettype wire

// File: doc/hazard_unit_mc.md
HAZARD_UNIT_MC -- requirements
Module: hazard_unit_mc

Interface
REQ-001 Parameter REG_ADDR_W, default 5, width of register-index ports.
REQ-002 Parameter MC_LAT, default 4, multi-cycle EX op latency in stall cycles; legal range 2..15.
REQ-003 Parameter CNT_W, default 16, width of stall performance counter.
REQ-004 CPU_CLK  in  1  sole clock, all state on rising edge.
REQ-005 CPU_RST_N  in  1  asynchronous, active-low reset.
REQ-006 ICacheMiss, DCacheMiss  in  1 each  cache miss, hold pipeline.
REQ-007 BranchE, JalrE, JalD  in  1 each  taken branch / jalr resolved in EX; jal resolved in ID.
REQ-008 Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  in  REG_ADDR_W each  register indices per stage.
REQ-009 RegReadE  in  2  bit1 = EX uses rs1, bit0 = EX uses rs2.
REQ-010 MemToRegE, RegWriteM, RegWriteW  in  3 each  nonzero = load in EX / write-back pending in MEM / WB.
REQ-011 McStartE  in  1  multi-cycle op (mul/div) occupies EX; held high while that instruction sits in EX.
REQ-012 PerfClr  in  1  synchronous clear of stall counter.
REQ-013 StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW  out  1 each  per-stage stall/flush.
REQ-014 Forward1E, Forward2E  out  2 each  00 register file, 01 WB result, 10 MEM result.
REQ-015 McBusy  out  1  high while multi-cycle FSM is not IDLE.
REQ-016 PerfStallCnt  out  CNT_W  count of cycles with StallF high.

Function
REQ-017 Stall/flush vector SHALL be combinational, priority highest first: miss > mc-stall > branch/jalr > load-use > JalD > none.
REQ-018 Miss (ICacheMiss|DCacheMiss): all Stall*=1, all Flush*=0; MC FSM and counter frozen.
REQ-019 Mc-stall (FSM IDLE with McStartE, or FSM BUSY): StallF/D/E=1, FlushM=1, others 0.
REQ-020 Branch (BranchE|JalrE): FlushD=1, FlushE=1, others 0; ignored while mc-stall active.
REQ-021 Load-use (MemToRegE!=0, RdE!=0, RdE equal to Rs1D or Rs2D): StallF=1, StallD=1, FlushE=1, others 0.
REQ-022 JalD: FlushD=1 only.
REQ-023 MC FSM states IDLE, BUSY, DONE; reset state IDLE; 4-bit down-counter McCnt, reset 0.
REQ-024 IDLE: McStartE and no miss -> BUSY, McCnt=MC_LAT-2; else stay.
REQ-025 BUSY: McCnt==0 -> DONE, else McCnt decrements by 1; no transition during miss.
REQ-026 DONE: no mc-stall asserted (instruction leaves EX); next state IDLE unconditionally unless miss (hold).
REQ-027 Net effect: exactly MC_LAT mc-stall cycles per multi-cycle op, instruction advances on cycle MC_LAT+1 absent misses.
REQ-028 McStartE seen in DONE SHALL NOT restart the FSM; a back-to-back op restarts from IDLE next cycle.
REQ-029 Forward1E=10 if RegWriteM!=0, RegReadE[1], RdM==Rs1E, RdM!=0; else 01 if same with W; else 00; MEM beats WB.
REQ-030 Forward2E identical using RegReadE[0] and Rs2E.
REQ-031 PerfStallCnt increments by 1 on each edge with StallF=1, saturates at all-ones; PerfClr forces 0 and wins over increment.

Reset
REQ-032 While CPU_RST_N=0: FSM IDLE, McCnt=0, PerfStallCnt=0, McBusy=0, all Flush*=1, all Stall*=0, Forward*=00, independent of clock.
REQ-033 Deassertion mid-operation SHALL resume from IDLE; a McStartE present on the first post-reset edge starts a fresh op.

Verification
REQ-034 RdE=5, MemToRegE=1, Rs1D=5 -> StallF=StallD=FlushE=1; repeat with RdE=0 -> no stall.
REQ-035 McStartE held 5 cycles, MC_LAT=4 -> StallE=1 cycles 1-4, 0 on cycle 5, McBusy high cycles 2-5, PerfStallCnt=4.
REQ-036 DCacheMiss for 3 cycles during BUSY with McCnt=1 -> all Stall*=1, McCnt holds 1, op completes 3 cycles late.
REQ-037 RdM=RdW=Rs1E=7, both writing, RegReadE=10 -> Forward1E=10, Forward2E=00; RdM=0 -> Forward1E=01.
REQ-038 CPU_RST_N low while BUSY -> immediate all Flush*=1, McBusy=0; PerfStallCnt=0 after release.
REQ-039 BranchE with McStartE in IDLE -> mc-stall vector, FlushD=0; PerfClr with StallF=1 -> counter 0.
